// File: rtl/sync_debounce_ctrl.sv
// sync_debounce_ctrl
//   Front end for NCH asynchronous pad inputs. The inputs go through a shared
//   DP-flop synchroniser. A debounce FSM per channel then qualifies level
//   changes and latches the selected edges as sticky W1C pending flags. A single
//   registered interrupt is raised from the pending flags that are unmasked.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   din[NCH]        raw asynchronous inputs
//   cfg_en          per-channel enable (0 = bypass debounce, no events)
//   cfg_rise_en     latch qualified rising edges
//   cfg_fall_en     latch qualified falling edges
//   cfg_irq_en      per-channel interrupt mask
//   cfg_deb_cycles  debounce length in cycles (0 behaves as 1)
//   clr             write-1-to-clear for pend_o
//   level_o         debounced level
//   pend_o          sticky edge-pending flags
//   irq_o           registered |(pend_o & cfg_irq_en)

// DP-stage synchroniser, W bits wide, reset to 0.
module gen_ticks_sync #(
  parameter int DP = 2,
  parameter int W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DP-1:0][W-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int k = 1; k < DP; k++) ff[k] <= ff[k-1];
    end
  end

  assign q = ff[DP-1];
endmodule

// One debounce channel: FSM, counter and sticky pending flag.
module sync_debounce_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             en,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clr,
  input  logic [CNT_W-1:0] deb_d,
  output logic             level,
  output logic             pend
);
  typedef enum logic [1:0] {S_LO, S_CHK_HI, S_HI, S_CHK_LO} state_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rise, fall;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // deb_d is the live value. When it is lowered below the running count,
  // the commit happens on the next cycle.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    rise  = 1'b0;
    fall  = 1'b0;
    if (!en) begin
      // A disabled channel tracks s directly. Because the FSM already matches s
      // when the channel is re-enabled, re-enabling produces no event.
      st_d  = s ? S_HI : S_LO;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        S_LO: begin
          if (s) begin st_d = S_CHK_HI; cnt_d = {{(CNT_W-1){1'b0}}, 1'b1}; end
          else   cnt_d = '0;
        end
        S_CHK_HI: begin
          if (!s) begin
            st_d  = S_LO;
            cnt_d = '0;
          end else if (cnt_q >= deb_d) begin
            st_d  = S_HI;
            cnt_d = '0;
            rise  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_HI: begin
          if (!s) begin st_d = S_CHK_LO; cnt_d = {{(CNT_W-1){1'b0}}, 1'b1}; end
          else    cnt_d = '0;
        end
        S_CHK_LO: begin
          if (s) begin
            st_d  = S_HI;
            cnt_d = '0;
          end else if (cnt_q >= deb_d) begin
            st_d  = S_LO;
            cnt_d = '0;
            fall  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          st_d  = S_LO;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_LO;
      cnt_q <= '0;
      pend  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      // If a set and a clear happen in the same cycle, the set wins.
      if ((rise && rise_en) || (fall && fall_en)) pend <= 1'b1;
      else if (clr)                              pend <= 1'b0;
    end
  end

  // The committed level is held in the HI side of the FSM.
  assign level = en ? ((st_q == S_HI) || (st_q == S_CHK_LO)) : s;
endmodule

module sync_debounce_ctrl #(
  parameter int NCH   = 4,
  parameter int DP    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   din,
  input  logic [NCH-1:0]   cfg_en,
  input  logic [NCH-1:0]   cfg_rise_en,
  input  logic [NCH-1:0]   cfg_fall_en,
  input  logic [NCH-1:0]   cfg_irq_en,
  input  logic [CNT_W-1:0] cfg_deb_cycles,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   level_o,
  output logic [NCH-1:0]   pend_o,
  output logic             irq_o
);
  logic [NCH-1:0]   s;
  logic [CNT_W-1:0] deb_d;

  assign deb_d = (cfg_deb_cycles == '0) ? CNT_W'(1) : cfg_deb_cycles;

  gen_ticks_sync #(.DP(DP), .W(NCH)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(din), .q(s)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    sync_debounce_lane #(.CNT_W(CNT_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .s      (s[i]),
      .en     (cfg_en[i]),
      .rise_en(cfg_rise_en[i]),
      .fall_en(cfg_fall_en[i]),
      .clr    (clr[i]),
      .deb_d  (deb_d),
      .level  (level_o[i]),
      .pend   (pend_o[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= |(pend_o & cfg_irq_en);
  end
endmodule

// File: tb/tb_sync_debounce_ctrl.sv
module tb_sync_debounce_ctrl;
  localparam int NCH = 4, DP = 2, CNT_W = 16;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [NCH-1:0]   din = '0, cfg_en = '1, cfg_rise_en = '1, cfg_fall_en = '1;
  logic [NCH-1:0]   cfg_irq_en = '1, clr = '0;
  logic [CNT_W-1:0] cfg_deb_cycles = 16'd4;
  logic [NCH-1:0]   level_o, pend_o;
  logic             irq_o;

  sync_debounce_ctrl #(.NCH(NCH), .DP(DP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .cfg_en(cfg_en),
    .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en),
    .cfg_irq_en(cfg_irq_en), .cfg_deb_cycles(cfg_deb_cycles), .clr(clr),
    .level_o(level_o), .pend_o(pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int             at;
    string          name;
    logic [NCH-1:0] lm, lv, pm, pv;
    logic           im, iv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;

  function automatic void expect_at(input int at, input string name,
                                    input logic [NCH-1:0] lm, input logic [NCH-1:0] lv,
                                    input logic [NCH-1:0] pm, input logic [NCH-1:0] pv,
                                    input logic im, input logic iv);
    exp_t e;
    int   i;
    e.at = at; e.name = name; e.lm = lm; e.lv = lv; e.pm = pm; e.pv = pv;
    e.im = im; e.iv = iv;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  // Monitor: samples on the falling edge and consumes every expectation due now.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.at < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.at, cyc);
      end else if ((((level_o ^ e.lv) & e.lm) !== '0) ||
                   (((pend_o ^ e.pv) & e.pm) !== '0) ||
                   (e.im && (irq_o !== e.iv))) begin
        errors++;
        $display("FAIL %s @cyc %0d: got level=%b pend=%b irq=%b, need level=%b/%b pend=%b/%b irq=%b/%b (value/mask)",
                 e.name, cyc, level_o, pend_o, irq_o, e.lv, e.lm, e.pv, e.pm, e.iv, e.im);
      end
    end
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t, e0, e1, a;
    // 1. reset state, then 50 quiet cycles after release
    expect_at(1, "reset_state", '1, '0, '1, '0, 1'b1, 1'b0);
    goto_cyc(3);
    rst_n = 1'b1;
    for (int k = 4; k <= 53; k++) expect_at(k, "quiet_after_reset", '1, '0, '1, '0, 1'b1, 1'b0);
    goto_cyc(53);

    // 2. ch0 rising edge, D=4: commit DP+D=6 cycles after the sampling edge
    t = cyc; din[0] = 1'b1; e0 = t + 1;
    expect_at(e0 + 5, "rise_ch0_early", 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0);
    expect_at(e0 + 6, "rise_ch0_commit", 4'hF, 4'h1, 4'hF, 4'h1, 1'b1, 1'b0);
    expect_at(e0 + 7, "irq_after_pend", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    goto_cyc(e0 + 8);
    clr = 4'h1;
    expect_at(e0 + 9, "clr_ch0", 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    goto_cyc(e0 + 9);
    clr = 4'h0;
    expect_at(e0 + 10, "irq_drop", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    goto_cyc(e0 + 10);

    // 3. D=8, 5-cycle glitch on ch1 is filtered
    t = cyc; cfg_deb_cycles = 16'd8; din[1] = 1'b1;
    for (int k = 1; k <= 20; k++) expect_at(t + k, "glitch_ch1", 4'hF, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0);
    goto_cyc(t + 5);
    din[1] = 1'b0;
    goto_cyc(t + 20);

    // 4. D=0 acts as 1; ch3 rise not latched, fall latched
    t = cyc; cfg_deb_cycles = '0; cfg_rise_en = 4'b0111; din[3] = 1'b1; e0 = t + 1;
    expect_at(e0 + 2, "d0_rise_early", 4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    expect_at(e0 + 3, "d0_rise_commit", 4'h8, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0);
    goto_cyc(t + 3);
    din[3] = 1'b0; e1 = t + 4;
    expect_at(e1 + 2, "d0_fall_early", 4'h8, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0);
    expect_at(e1 + 3, "d0_fall_commit", 4'h8, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0);
    expect_at(e1 + 4, "d0_fall_irq", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    goto_cyc(e1 + 5);
    clr = 4'h8;
    expect_at(e1 + 6, "clr_ch3", 4'h0, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0);
    goto_cyc(e1 + 6);
    clr = 4'h0;
    expect_at(e1 + 7, "idle_after_ch3", 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    goto_cyc(e1 + 8);
    cfg_rise_en = '1;

    // 5. ch2 commit coincides with clr: set wins; then disable/re-enable
    t = cyc; cfg_deb_cycles = 16'd4; din[2] = 1'b1; e0 = t + 1;
    expect_at(e0 + 5, "ch2_pre_commit", 4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0);
    goto_cyc(e0 + 5);
    clr = 4'h4;
    expect_at(e0 + 6, "set_wins_over_clr", 4'h4, 4'h4, 4'h4, 4'h4, 1'b0, 1'b0);
    goto_cyc(e0 + 6);
    clr = 4'h0;
    expect_at(e0 + 7, "ch2_pend_held", 4'h0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b1);
    goto_cyc(e0 + 8);
    clr = 4'h4;
    expect_at(e0 + 9, "clr_ch2", 4'h0, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0);
    goto_cyc(e0 + 9);
    clr = 4'h0;
    expect_at(e0 + 10, "irq_drop_ch2", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    goto_cyc(e0 + 11);
    a = cyc; cfg_en[2] = 1'b0; din[2] = 1'b0;
    for (int k = 1; k <= 20; k++) expect_at(a + k, "disabled_no_event", 4'h0, 4'h0, 4'h4, 4'h0, 1'b1, 1'b0);
    expect_at(a + 1, "dis_level_hold", 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
    expect_at(a + 2, "dis_level_follows_s", 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    goto_cyc(a + 5);
    din[2] = 1'b1;
    expect_at(a + 6, "dis_level_low", 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    expect_at(a + 7, "dis_level_high", 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
    goto_cyc(a + 10);
    cfg_en[2] = 1'b1;
    expect_at(a + 20, "reenable_level", 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0);
    goto_cyc(a + 21);

    // 6. D=100 reprogrammed to 10 at cnt=50 commits next cycle; then async reset
    t = cyc; cfg_deb_cycles = 16'd100; din[1] = 1'b1; e0 = t + 1;
    expect_at(e0 + 51, "live_d_pre", 4'h2, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0);
    goto_cyc(e0 + 51);
    cfg_deb_cycles = 16'd10;
    expect_at(e0 + 52, "live_d_commit", 4'h2, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0);
    goto_cyc(e0 + 55);
    cfg_deb_cycles = 16'd100; din[3] = 1'b1;
    goto_cyc(e0 + 80);
    #2;
    rst_n = 1'b0;
    expect_at(cyc, "async_reset", '1, '0, '1, '0, 1'b1, 1'b0);
    expect_at(cyc + 2, "held_reset", '1, '0, '1, '0, 1'b1, 1'b0);
    goto_cyc(e0 + 83);
    rst_n = 1'b1;
    goto_cyc(cyc + 2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, need 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, need completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
